time_entry_ctrl: RTL and testbench

TIME_ENTRY_CTRL -- requirements
Module: time_entry_ctrl

---
 rtl/watch_pkg.sv | 41 ++++
 rtl/key_debounce.sv | 51 +++++
 rtl/time_entry_ctrl.sv | 159 +++++++++++++++
 tb/tb_time_entry_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : watch_pkg
// Brief    : Shared entry-FSM encoding, digit position codes and digit limits.
// Revision : 1.0 - initial release
// ============================================================================
package watch_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ENTRY = 1'b1
  } entry_state_e;

  localparam logic [2:0] c_POS_H_TEN = 3'd0;
  localparam logic [2:0] c_POS_H_ONE = 3'd1;
  localparam logic [2:0] c_POS_M_TEN = 3'd2;
  localparam logic [2:0] c_POS_M_ONE = 3'd3;
  localparam logic [2:0] c_POS_S_TEN = 3'd4;
  localparam logic [2:0] c_POS_S_ONE = 3'd5;
  // Marks "all six digits taken"; the FSM spends one cycle here before IDLE.
  localparam logic [2:0] c_POS_DONE  = 3'd6;

  localparam logic [3:0] c_LIM_H_TEN     = 4'd2;
  localparam logic [3:0] c_LIM_H_ONE     = 4'd9;
  localparam logic [3:0] c_LIM_H_ONE_20S = 4'd3;
  localparam logic [3:0] c_LIM_MS_TEN    = 4'd5;
  localparam logic [3:0] c_LIM_MS_ONE    = 4'd9;

  function automatic logic [3:0] digit_limit(input logic [2:0] pos, input logic [3:0] h_ten);
    logic [3:0] lim;
    case (pos)
      c_POS_H_TEN:              lim = c_LIM_H_TEN;
      c_POS_H_ONE:              lim = (h_ten == 4'd2) ? c_LIM_H_ONE_20S : c_LIM_H_ONE;
      c_POS_M_TEN, c_POS_S_TEN: lim = c_LIM_MS_TEN;
      default:                  lim = c_LIM_MS_ONE;
    endcase
    return lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-flop synchronizer plus whole-vector stability debounce counter.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int unsigned WIDTH        = 1,
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] deb_out
);

  localparam int unsigned         c_CNT_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_deb;
  logic [c_CNT_W-1:0] r_cnt;

  // The cycle a change is seen already counts as the first stable cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_sync2 != r_prev) begin
        r_cnt <= c_CNT_W'(1);
      end else if (r_cnt != c_CNT_LAST) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_deb <= r_sync2;
      end
    end
  end

  assign deb_out = r_deb;

endmodule
`default_nettype wire

// File: rtl/time_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_entry_ctrl
// Brief    : Debounced keypad front end and HH:MM:SS digit-entry sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module time_entry_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned TIMEOUT_CYC  = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  input  logic       set_key,
  output logic       set_time,
  output logic [3:0] digit_bcd,
  output logic [2:0] digit_pos,
  output logic       digit_valid,
  output logic       entry_busy,
  output logic       entry_err
);

  localparam int unsigned         c_TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

  logic [9:0]         w_key_deb;
  logic [0:0]         w_set_deb;
  logic [9:0]         r_key_prev;
  logic               r_set_prev;
  logic               w_key_press;
  logic               w_set_press;
  logic               w_multi;
  logic [3:0]         w_digit;

  entry_state_e       r_state,        w_state_nxt;
  logic [2:0]         r_pos,          w_pos_nxt;
  logic [3:0]         r_h_ten,        w_h_ten_nxt;
  logic [c_TMO_W-1:0] r_tmo,          w_tmo_nxt;
  logic               r_set_time,     w_set_time_nxt;
  logic [3:0]         r_digit_bcd,    w_bcd_nxt;
  logic [2:0]         r_digit_pos,    w_dpos_nxt;
  logic               r_digit_valid,  w_valid_nxt;
  logic               r_entry_err,    w_err_nxt;

  key_debounce #(.WIDTH(10), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_db (
    .clk     (clk),
    .rst     (rst),
    .raw_in  (key_in),
    .deb_out (w_key_deb)
  );

  key_debounce #(.WIDTH(1), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set_db (
    .clk     (clk),
    .rst     (rst),
    .raw_in  (set_key),
    .deb_out (w_set_deb)
  );

  // A press is only the step away from all-released, so chords grown key by key count once.
  assign w_key_press = (r_key_prev == '0) && (w_key_deb != '0);
  assign w_set_press = w_set_deb[0] & ~r_set_prev;
  assign w_multi     = (w_key_deb & (w_key_deb - 10'd1)) != '0;

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (w_key_deb[i]) w_digit = 4'(i);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pos_nxt      = r_pos;
    w_h_ten_nxt    = r_h_ten;
    w_tmo_nxt      = r_tmo;
    w_set_time_nxt = 1'b0;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_bcd_nxt      = r_digit_bcd;
    w_dpos_nxt     = r_digit_pos;
    case (r_state)
      ST_IDLE: begin
        if (w_set_press) begin
          w_set_time_nxt = 1'b1;
          w_pos_nxt      = c_POS_H_TEN;
          w_tmo_nxt      = '0;
          w_state_nxt    = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (w_set_press) begin
          w_set_time_nxt = 1'b1;
          w_pos_nxt      = c_POS_H_TEN;
          w_tmo_nxt      = '0;
        end else if (r_pos == c_POS_DONE) begin
          w_state_nxt = ST_IDLE;
        end else if (w_key_press) begin
          w_tmo_nxt = '0;
          if (w_multi) begin
            w_err_nxt = 1'b1;
          end else if (w_digit <= digit_limit(r_pos, r_h_ten)) begin
            w_valid_nxt = 1'b1;
            w_bcd_nxt   = w_digit;
            w_dpos_nxt  = r_pos;
            w_pos_nxt   = r_pos + 3'd1;
            if (r_pos == c_POS_H_TEN) w_h_ten_nxt = w_digit;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (r_tmo == c_TMO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_key_prev    <= '0;
      r_set_prev    <= 1'b0;
      r_pos         <= c_POS_H_TEN;
      r_h_ten       <= '0;
      r_tmo         <= '0;
      r_set_time    <= 1'b0;
      r_digit_bcd   <= '0;
      r_digit_pos   <= '0;
      r_digit_valid <= 1'b0;
      r_entry_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key_prev    <= w_key_deb;
      r_set_prev    <= w_set_deb[0];
      r_pos         <= w_pos_nxt;
      r_h_ten       <= w_h_ten_nxt;
      r_tmo         <= w_tmo_nxt;
      r_set_time    <= w_set_time_nxt;
      r_digit_bcd   <= w_bcd_nxt;
      r_digit_pos   <= w_dpos_nxt;
      r_digit_valid <= w_valid_nxt;
      r_entry_err   <= w_err_nxt;
    end
  end

  assign set_time    = r_set_time;
  assign digit_bcd   = r_digit_bcd;
  assign digit_pos   = r_digit_pos;
  assign digit_valid = r_digit_valid;
  assign entry_err   = r_entry_err;
  assign entry_busy  = (r_state == ST_ENTRY);

endmodule
`default_nettype wire

// File: tb/tb_time_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_entry_ctrl
// Brief    : Self-checking bench for time_entry_ctrl against an event-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_entry_ctrl;

  localparam int c_DEB  = 8;
  localparam int c_TMO  = 300;
  localparam int c_HOLD = c_DEB + 8;

  // kind: 0 set_time, 1 digit_valid, 2 entry_err, 3 none
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] val;
    logic [2:0] pos;
  } ev_t;
  localparam ev_t c_EV_NONE = 9'b11_0000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_in = '0;
  logic       set_key = 1'b0;
  logic       set_time;
  logic [3:0] digit_bcd;
  logic [2:0] digit_pos;
  logic       digit_valid;
  logic       entry_busy;
  logic       entry_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0, n_err = 0, n_overlap = 0;
  int valid_cyc = 0, err_cyc = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  int m_entry = 0, m_pos = 0, m_hten = 0;
  int lim_tab [6] = '{2, 9, 5, 9, 5, 9};

  time_entry_ctrl #(.DEBOUNCE_CYC(c_DEB), .TIMEOUT_CYC(c_TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .set_key     (set_key),
    .set_time    (set_time),
    .digit_bcd   (digit_bcd),
    .digit_pos   (digit_pos),
    .digit_valid (digit_valid),
    .entry_busy  (entry_busy),
    .entry_err   (entry_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (set_time) obs_q.push_back({2'd0, 4'd0, 3'd0});
      if (digit_valid) begin
        obs_q.push_back({2'd1, digit_bcd, digit_pos});
        n_valid++;
        valid_cyc = cyc;
      end
      if (entry_err) begin
        obs_q.push_back({2'd2, 4'd0, 3'd0});
        n_err++;
        err_cyc = cyc;
      end
      if (digit_valid && entry_err) n_overlap++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int kind, input int val, input int pos);
    ev_t e;
    e.kind = 2'(kind);
    e.val  = 4'(val);
    e.pos  = 3'(pos);
    exp_q.push_back(e);
  endtask

  task automatic model_set();
    push_exp(0, 0, 0);
    m_entry = 1;
    m_pos   = 0;
  endtask

  task automatic model_key(input logic [9:0] mask);
    int d, lim;
    if (m_entry == 0 || mask == '0) return;
    if ($countones(mask) > 1) begin
      push_exp(2, 0, 0);
      return;
    end
    d = 0;
    for (int i = 0; i < 10; i++) if (mask[i]) d = i;
    lim = lim_tab[m_pos];
    if (m_pos == 1 && m_hten == 2) lim = 3;
    if (d <= lim) begin
      push_exp(1, d, m_pos);
      if (m_pos == 0) m_hten = d;
      m_pos++;
      if (m_pos == 6) m_entry = 0;
    end else begin
      push_exp(2, 0, 0);
    end
  endtask

  task automatic press_set();
    model_set();
    @(negedge clk); set_key = 1'b1;
    wait_cyc(c_HOLD);
    set_key = 1'b0;
    wait_cyc(c_HOLD);
  endtask

  task automatic press_key(input logic [9:0] mask);
    model_key(mask);
    @(negedge clk); key_in = mask;
    wait_cyc(c_HOLD);
    key_in = '0;
    wait_cyc(c_HOLD);
  endtask

  task automatic test_reset();
    rst = 1'b1; key_in = '0; set_key = 1'b0;
    wait_cyc(3);
    total++; if (set_time !== 1'b0)    begin bad++; $display("FAIL reset_set_time: got %b required 0", set_time); end
    total++; if (digit_bcd !== 4'd0)   begin bad++; $display("FAIL reset_digit_bcd: got %0d required 0", digit_bcd); end
    total++; if (digit_pos !== 3'd0)   begin bad++; $display("FAIL reset_digit_pos: got %0d required 0", digit_pos); end
    total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL reset_digit_valid: got %b required 0", digit_valid); end
    total++; if (entry_busy !== 1'b0)  begin bad++; $display("FAIL reset_entry_busy: got %b required 0", entry_busy); end
    total++; if (entry_err !== 1'b0)   begin bad++; $display("FAIL reset_entry_err: got %b required 0", entry_err); end
    rst = 1'b0;
    m_entry = 0;
    wait_cyc(c_HOLD);
    total++; if (entry_busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got busy=%b required 0", entry_busy); end
  endtask

  task automatic test_full_entry();
    int v0;
    int digits [6] = '{2, 3, 5, 9, 5, 9};
    v0 = n_valid;
    press_set();
    for (int i = 0; i < 6; i++) press_key(10'b1 << digits[i]);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL full_entry_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
    total++; if (n_valid - v0 !== 6) begin bad++; $display("FAIL full_entry_count: got %0d strobes required 6", n_valid - v0); end
    total++; if (entry_busy !== 1'b0) begin bad++; $display("FAIL full_entry_busy: got %b required 0", entry_busy); end
  endtask

  task automatic test_hour_limit();
    press_set();
    press_key(10'b1 << 2);
    press_key(10'b1 << 4);
    press_key(10'b1 << 3);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL hour_limit_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
    total++; if (entry_busy !== 1'b1) begin bad++; $display("FAIL hour_limit_busy: got %b required 1", entry_busy); end
  endtask

  task automatic test_multi_key();
    press_key((10'b1 << 1) | (10'b1 << 7));
    press_key(10'b1 << 5);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL multi_key_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
    total++; if (entry_busy !== 1'b1) begin bad++; $display("FAIL multi_key_busy: got %b required 1", entry_busy); end
  endtask

  task automatic test_timeout();
    int e0, lat;
    e0 = n_err;
    push_exp(2, 0, 0);
    m_entry = 0;
    for (int k = 0; k < c_TMO + 60 && n_err == e0; k++) @(negedge clk);
    total++;
    if (n_err == e0) begin
      bad++; $display("FAIL timeout_err: got no entry_err required one within %0d cycles", c_TMO + 60);
    end else begin
      lat = err_cyc - valid_cyc;
      total++;
      if (lat < c_TMO - 1 || lat > c_TMO + 1) begin bad++; $display("FAIL timeout_latency: got %0d cycles required %0d", lat, c_TMO); end
    end
    wait_cyc(2);
    total++; if (entry_busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b required 0", entry_busy); end
    press_key(10'b1 << 3);
    press_key(10'b1 << 7);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL timeout_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
  endtask

  task automatic test_bounce();
    int v0, t_settle, lat;
    logic [9:0] mask;
    mask = 10'b1 << 1;
    press_set();
    v0 = n_valid;
    model_key(mask);
    t_settle = cyc;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      key_in = (g % 2 == 0) ? mask : 10'd0;
      t_settle = cyc;
      wait_cyc(4);
    end
    for (int k = 0; k < c_DEB + 20 && n_valid == v0; k++) @(negedge clk);
    total++;
    if (n_valid == v0) begin
      bad++; $display("FAIL bounce_strobe: got none required one within %0d cycles", c_DEB + 20);
    end else begin
      lat = valid_cyc - t_settle;
      total++;
      if (lat < c_DEB + 2 || lat > c_DEB + 4) begin bad++; $display("FAIL bounce_latency: got %0d required %0d+-1", lat, c_DEB + 3); end
    end
    wait_cyc(c_HOLD);
    key_in = '0;
    wait_cyc(c_HOLD);
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL bounce_count: got %0d strobes required 1", n_valid - v0); end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL bounce_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    press_set();
    press_key(10'b1 << 1);
    press_key(10'b1 << 2);
    model_key(10'b1 << 5);
    @(negedge clk); key_in = 10'b1 << 5;
    seen = 1'b0;
    for (int k = 0; k < c_DEB + 20 && !seen; k++) begin
      @(negedge clk);
      if (digit_valid) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL reset_mid_strobe: got none required digit_valid before reset"); end
    #1 rst = 1'b1;
    #1;
    total++; if (digit_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid: got %b required 0", digit_valid); end
    total++; if (digit_pos !== 3'd0)   begin bad++; $display("FAIL reset_mid_pos: got %0d required 0", digit_pos); end
    total++; if (digit_bcd !== 4'd0)   begin bad++; $display("FAIL reset_mid_bcd: got %0d required 0", digit_bcd); end
    total++; if (entry_busy !== 1'b0)  begin bad++; $display("FAIL reset_mid_busy: got %b required 0", entry_busy); end
    total++; if ((set_time | entry_err) !== 1'b0) begin bad++; $display("FAIL reset_mid_pulses: got set=%b err=%b required 0", set_time, entry_err); end
    key_in  = '0;
    m_entry = 0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(c_HOLD);
    press_set();
    press_key(10'b1 << 2);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_mid_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
  endtask

  task automatic test_random();
    int r, a, b, lim;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) begin
        press_set();
      end else if (r < 22) begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        press_key((10'b1 << a) | (10'b1 << b));
      end else begin
        lim = 9;
        if (m_entry != 0) begin
          lim = lim_tab[m_pos];
          if (m_pos == 1 && m_hten == 2) lim = 3;
        end
        a = ($urandom_range(0, 3) != 0) ? $urandom_range(0, lim) : $urandom_range(0, 9);
        press_key(10'b1 << a);
      end
      total++;
      if (entry_busy !== (m_entry != 0)) begin bad++; $display("FAIL random_busy: step %0d got %b required %0d", n, entry_busy, m_entry); end
    end
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      ev_t e; ev_t o;
      e = c_EV_NONE; o = c_EV_NONE;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL random_event: got kind=%0d val=%0d pos=%0d required kind=%0d val=%0d pos=%0d", o.kind, o.val, o.pos, e.kind, e.val, e.pos); end
    end
    total++;
    if (n_overlap !== 0) begin bad++; $display("FAIL valid_err_overlap: got %0d cycles required 0", n_overlap); end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_hour_limit();
    test_multi_key();
    test_timeout();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
